// File: rtl/fp8_pkg.sv
// rtl/fp8_pkg.sv - shared fp8 format constants and divider state encoding
package fp8_pkg;

   localparam int EXP_BIAS_DEFAULT = 3;
   localparam int SIGN_W  = 1;
   localparam int EXP_W   = 3;
   localparam int MANT_W  = 4;
   localparam int FRACT_W = 5;
   localparam int Q_W     = 10;
   localparam int FP8_W   = SIGN_W + EXP_W + MANT_W;

   localparam logic [FP8_W-1:0] FP8_ZERO   = 8'h00;
   localparam logic [FP8_W-2:0] FP8_MAXMAG = 7'h7F;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DIV  = 2'd1,
      NORM = 2'd2,
      DONE = 2'd3
   } state_t;

endpackage

// File: rtl/fp8_div_core.sv
// rtl/fp8_div_core.sv - restoring divider, one quotient bit per step
module fp8_div_core
   import fp8_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               step,
   input  logic [Q_W-1:0]     dividend,
   input  logic [FRACT_W-1:0] divisor,
   output logic [Q_W-1:0]     quotient,
   output logic               done
);

   logic [FRACT_W-1:0] rem;
   logic [FRACT_W-1:0] dvsr;
   logic [3:0]         cnt;
   logic [FRACT_W:0]   trial;
   logic               fits;

   // The quotient register doubles as the dividend shifter: its MSB feeds the remainder.
   assign trial = {rem, quotient[Q_W-1]};
   assign fits  = (trial >= {1'b0, dvsr});
   assign done  = step && (cnt == 4'(Q_W - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rem      <= '0;
         dvsr     <= '0;
         quotient <= '0;
         cnt      <= '0;
      end else if (start) begin
         rem      <= '0;
         dvsr     <= divisor;
         quotient <= dividend;
         cnt      <= '0;
      end else if (step) begin
         rem      <= fits ? FRACT_W'(trial - {1'b0, dvsr}) : trial[FRACT_W-1:0];
         quotient <= {quotient[Q_W-2:0], fits};
         cnt      <= cnt + 4'd1;
      end
   end

endmodule

// File: rtl/fp_div_8bit_seq.sv
// rtl/fp_div_8bit_seq.sv - sequential fp8 divider with valid/ready handshakes
module fp_div_8bit_seq
   import fp8_pkg::*;
#(
   parameter int EXP_BIAS = EXP_BIAS_DEFAULT
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [FP8_W-1:0] flp_a,
   input  logic [FP8_W-1:0] flp_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [FP8_W-1:0] result,
   output logic             ovf,
   output logic             unf,
   output logic             dbz
);

   state_t             state;
   logic               sign_r;
   logic [EXP_W-1:0]   exp_a_r;
   logic [EXP_W-1:0]   exp_b_r;
   logic [EXP_W-1:0]   exp_a;
   logic [EXP_W-1:0]   exp_b;
   logic [FRACT_W-1:0] fract_a;
   logic [FRACT_W-1:0] fract_b;
   logic               sign;
   logic               a_zero;
   logic               b_zero;
   logic               start;
   logic               core_done;
   logic [Q_W-1:0]     quotient;
   logic [3:0]         lead;
   logic [Q_W-1:0]     q_norm;
   logic [MANT_W-1:0]  mant;
   logic signed [5:0]  e_res;

   assign exp_a   = flp_a[6:4];
   assign exp_b   = flp_b[6:4];
   assign fract_a = {exp_a != '0, flp_a[3:0]};
   assign fract_b = {exp_b != '0, flp_b[3:0]};
   assign sign    = flp_a[7] ^ flp_b[7];
   assign a_zero  = (flp_a[6:0] == 7'd0);
   assign b_zero  = (flp_b[6:0] == 7'd0);

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign start     = in_ready && in_valid && !a_zero && !b_zero;

   fp8_div_core u_core (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .step     (state == DIV),
      .dividend ({fract_a, 5'b0}),
      .divisor  (fract_b),
      .quotient (quotient),
      .done     (core_done)
   );

   always_comb begin
      lead = '0;
      for (int i = 0; i < Q_W; i++) begin
         if (quotient[i]) lead = 4'(i);
      end
   end

   // Left-justify Q so the mantissa always sits directly under bit Q_W-1.
   assign q_norm = quotient << (4'(Q_W - 1) - lead);
   assign mant   = MANT_W'(q_norm >> (Q_W - 1 - MANT_W));
   assign e_res  = 6'(exp_a_r) - 6'(exp_b_r) + 6'(EXP_BIAS) + 6'(lead) - 6'd5;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         result  <= FP8_ZERO;
         ovf     <= 1'b0;
         unf     <= 1'b0;
         dbz     <= 1'b0;
         sign_r  <= 1'b0;
         exp_a_r <= '0;
         exp_b_r <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  sign_r  <= sign;
                  exp_a_r <= exp_a;
                  exp_b_r <= exp_b;
                  if (b_zero) begin
                     result <= {sign, FP8_MAXMAG};
                     ovf    <= 1'b0;
                     unf    <= 1'b0;
                     dbz    <= 1'b1;
                     state  <= DONE;
                  end else if (a_zero) begin
                     result <= FP8_ZERO;
                     ovf    <= 1'b0;
                     unf    <= 1'b0;
                     dbz    <= 1'b0;
                     state  <= DONE;
                  end else begin
                     state  <= DIV;
                  end
               end
            end
            DIV: begin
               if (core_done) state <= NORM;
            end
            NORM: begin
               dbz <= 1'b0;
               if (e_res > 6'sd7) begin
                  result <= {sign_r, FP8_MAXMAG};
                  ovf    <= 1'b1;
                  unf    <= 1'b0;
               end else if (e_res < 6'sd1) begin
                  result <= FP8_ZERO;
                  ovf    <= 1'b0;
                  unf    <= 1'b1;
               end else begin
                  result <= {sign_r, e_res[2:0], mant};
                  ovf    <= 1'b0;
                  unf    <= 1'b0;
               end
               state <= DONE;
            end
            DONE: begin
               if (out_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fp_div_8bit_seq.sv
// tb/tb_fp_div_8bit_seq.sv - directed self-checking bench for fp_div_8bit_seq
module tb_fp_div_8bit_seq;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic       out_ready = 1'b1;
   logic [7:0] flp_a = 8'h00;
   logic [7:0] flp_b = 8'h00;
   logic       in_ready;
   logic       out_valid;
   logic [7:0] result;
   logic       ovf;
   logic       unf;
   logic       dbz;

   int n_checks = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   fp_div_8bit_seq #(.EXP_BIAS(3)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .flp_a     (flp_a),
      .flp_b     (flp_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .ovf       (ovf),
      .unf       (unf),
      .dbz       (dbz)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic wait_out(output int lat);
      lat = 1;
      while (out_valid !== 1'b1 && lat < 40) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic xact(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] er, input logic [2:0] eflags, input int elat);
      int lat;
      @(negedge clk);
      flp_a = a;
      flp_b = b;
      in_valid = 1'b1;
      out_ready = 1'b1;
      check({tag, " in_ready"}, 32'(in_ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      flp_a = 8'h00;
      flp_b = 8'h00;
      wait_out(lat);
      check({tag, " latency"}, 32'(lat), 32'(elat));
      check({tag, " result"}, 32'(result), 32'(er));
      check({tag, " ovf/unf/dbz"}, 32'({ovf, unf, dbz}), 32'(eflags));
   endtask

   initial begin
      int lat;
      logic held;

      #12;
      check("reset in_ready", 32'(in_ready), 32'd1);
      check("reset out_valid", 32'(out_valid), 32'd0);
      check("reset result", 32'(result), 32'h00);
      check("reset flags", 32'({ovf, unf, dbz}), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      xact("1.0/1.0",      8'h30, 8'h30, 8'h30, 3'b000, 12);
      xact("2.0/1.5",      8'h40, 8'h38, 8'h35, 3'b000, 12);
      xact("-1.0/2.0",     8'hB0, 8'h40, 8'hA0, 3'b000, 12);
      xact("subnormals",   8'h0F, 8'h08, 8'h3E, 3'b000, 12);
      xact("e=7 edge",     8'h70, 8'h30, 8'h70, 3'b000, 12);
      xact("e=1 edge",     8'h10, 8'h30, 8'h10, 3'b000, 12);
      xact("overflow",     8'h7F, 8'h10, 8'h7F, 3'b100, 12);
      xact("underflow",    8'h10, 8'h7F, 8'h00, 3'b010, 12);
      xact("div by zero",  8'h45, 8'h80, 8'hFF, 3'b001, 1);
      xact("zero dividend",8'h00, 8'h45, 8'h00, 3'b000, 1);
      xact("neg zero/pos", 8'h80, 8'h45, 8'h00, 3'b000, 1);
      xact("0/0 dbz prio", 8'h00, 8'h00, 8'h7F, 3'b001, 1);

      // Backpressure with a new operand pair waiting on the input side
      @(negedge clk);
      flp_a = 8'h40;
      flp_b = 8'h38;
      in_valid = 1'b1;
      out_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      flp_a = 8'h30;
      flp_b = 8'h30;
      wait_out(lat);
      check("bp latency", 32'(lat), 32'd12);
      held = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (result !== 8'h35 || in_ready !== 1'b0 || out_valid !== 1'b1 || {ovf, unf, dbz} !== 3'b000)
            held = 1'b0;
      end
      check("bp held 20 cycles", 32'(held), 32'd1);
      check("bp result", 32'(result), 32'h35);
      check("bp in_ready", 32'(in_ready), 32'd0);
      out_ready = 1'b1;
      @(negedge clk);
      check("bp release out_valid", 32'(out_valid), 32'd0);
      check("bp release in_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      check("bp next accepted", 32'(in_ready), 32'd0);
      wait_out(lat);
      check("bp next latency", 32'(lat), 32'd12);
      check("bp next result", 32'(result), 32'h30);

      xact("pre-reset ovf", 8'h7F, 8'h10, 8'h7F, 3'b100, 12);

      // Asynchronous reset in the middle of the iterations
      @(negedge clk);
      flp_a = 8'h40;
      flp_b = 8'h38;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("midreset in_ready", 32'(in_ready), 32'd1);
      check("midreset out_valid", 32'(out_valid), 32'd0);
      check("midreset result", 32'(result), 32'h00);
      check("midreset flags", 32'({ovf, unf, dbz}), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      xact("post-reset 1.0/1.0", 8'h30, 8'h30, 8'h30, 3'b000, 12);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/fp_div_8bit_seq.md
Name: fp_div_8bit_seq

Overview:
Sequential 8-bit floating-point divider, result = flp_a / flp_b. It is the inverse of the team's combinational fp8 multiplier and uses the same format: bit7 sign, [6:4] exponent with bias 3, [3:0] mantissa, hidden 1 when exponent != 0. The block computes one quotient bit per cycle with a restoring divider and exchanges operands and results over valid/ready handshakes. It sits beside the multiplier in the fp8 arithmetic datapath.

Parameters:
EXP_BIAS, 3, exponent bias added back to the result exponent; must match the multiplier.

Ports:
clk  input  1  single clock; all state updates on the rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand pair present on flp_a/flp_b
in_ready  output  1  block accepts operands; high only in IDLE
flp_a  input  8  dividend (fp8)
flp_b  input  8  divisor (fp8)
out_valid  output  1  result and flags valid
out_ready  input  1  consumer accepts the result
result  output  8  fp8 quotient
ovf  output  1  exponent overflow; result saturated
unf  output  1  exponent underflow; result flushed to zero
dbz  output  1  divide by zero

Behaviour:
- Reset (asynchronous, any state, including mid-division): state=IDLE, in_ready=1, out_valid=0, result=0x00, ovf=unf=dbz=0, iteration counter=0, partial remainder and quotient=0.
- States: IDLE, DIV, NORM, DONE.
- IDLE: when in_valid && in_ready, capture the operands.
  - sign = a[7]^b[7].
  - fract_x = {exp_x!=0, mant_x} (5 bits).
  - An exponent field of 0 is used as value 0.
- Special cases are resolved on the capture edge and go straight to DONE:
  - b[6:0]==0: result = {sign,7'h7F}, dbz=1. This has priority over a zero.
  - a[6:0]==0 with b nonzero: result = 0x00 (sign forced to 0), all flags 0.
- Normal path: IDLE→DIV.
  - Dividend = fract_a<<5 (10 bits), divisor = fract_b.
  - Ten restoring iterations, one per cycle, MSB first, producing Q = floor(fract_a*32/fract_b). Q is 10 bits and always >= 1.
  - After the 10th iteration go to NORM.
- NORM, one cycle, then → DONE:
  - p = index of the leading one in Q (0..9).
  - mant = the 4 bits below the leading one, zero-padded on the right when p<4; remaining bits truncated.
  - e = exp_a - exp_b + EXP_BIAS + (p-5), computed as 6-bit signed.
  - e>=8: result = {sign,7'h7F}, ovf=1.
  - e<=0: result = 0x00, unf=1.
  - Otherwise result = {sign,e[2:0],mant}.
- Latency: the handshake edge is k.
  - Normal path: out_valid rises after edge k+11.
  - Special cases: out_valid rises after edge k.
- DONE:
  - out_valid=1, in_ready=0.
  - result and flags hold stable while out_ready=0 (backpressure, indefinitely).
  - On out_valid && out_ready, go to IDLE with out_valid=0. There is no same-cycle accept of a new operand.
  - result and flags keep their last values in IDLE; only out_valid qualifies them.
- Operands are ignored outside IDLE. Changing flp_a/flp_b during DIV has no effect.
- in_valid may stay high continuously. Throughput is one result per 13 cycles on the normal path when out_ready=1.

Decomposition:
- Package fp8_pkg:
  - EXP_BIAS default, field widths (SIGN_W=1, EXP_W=3, MANT_W=4, FRACT_W=5, Q_W=10).
  - State enum {IDLE,DIV,NORM,DONE}.
  - Constants FP8_ZERO=8'h00 and FP8_MAXMAG=7'h7F.
- One sub-module, fp8_div_core: the restoring iteration datapath with a start/step interface, remainder/quotient registers and a 4-bit counter, signalling done after 10 steps.
- fp_div_8bit_seq holds the handshake FSM, special-case detection and normalisation/packing.

Test Plan:
- 0x30/0x30 (1.0/1.0): Q=32 → result 0x30, flags 0, out_valid exactly 12 edges after the handshake.
- 0x40/0x38 (2.0/1.5): Q=21, p=4 → result 0x35 (1.3125, truncated), flags 0. 0xB0/0x40 → 0xA0 (-0.5).
- Overflow and underflow:
  - 0x7F/0x10: Q=62, e=9 → 0x7F, ovf=1.
  - 0x10/0x7F: Q=16, e=-4 → 0x00, unf=1.
- 0x45/0x80 → result 0xFF, dbz=1, out_valid after 1 edge. 0x00/0x45 → 0x00, flags 0, 1-edge latency.
- Backpressure: hold out_ready=0 for 20 cycles with in_valid=1 and new operands → result held, in_ready=0, new operands not captured; release → IDLE, next pair accepted the following edge.
- Drop rst_n at iteration 5 → outputs reset immediately (asynchronously). After release, a fresh 0x30/0x30 completes correctly with no leftover remainder state.
